// File: rtl/frame_draw_scheduler_pkg.sv
// Shared types and constants for the frame draw scheduler and its arbiter.
package frame_draw_scheduler_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SLIDE_START = 3'd1,
    SLIDE_ARM   = 3'd2,
    SLIDE_RUN   = 3'd3,
    ARB         = 3'd4,
    DRAW        = 3'd5
  } sched_state_e;

  // Pointer width for an n-way round-robin; never narrower than one bit.
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_draw_scheduler_rr_arbiter_pick.sv
// Combinational round-robin pick: first valid requester at or above rrPtr, wrapping.
module rr_arbiter_pick
  import frame_draw_scheduler_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = ptrWidth(N)
) (
  input  logic [N-1:0]     reqValid,
  input  logic [PTR_W-1:0] rrPtr,
  output logic [N-1:0]     pick,
  output logic             anyValid
);

  // Walk the requesters starting at rrPtr and take the first valid one.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    anyValid = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rrPtr) + i;
      if (idx >= N) idx = idx - N;
      if (!anyValid && reqValid[idx]) begin
        pick[idx] = 1'b1;
        anyValid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer and VGA write-port arbiter: runs the screen slider once
// per frame tick, then shares the VGA write port round-robin among draw engines.
// Optional macro FRAME_SCHED_OVERRUN_EN adds overrunCount/overrun outputs that
// record frame ticks dropped while the scheduler was busy.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int         NUM_REQ    = 3,
  parameter logic [7:0] SLIDE_X_LO = 8'd0,
  parameter logic [7:0] SLIDE_X_HI = 8'd158,
  parameter logic [6:0] SLIDE_Y_LO = 7'd0,
  parameter logic [6:0] SLIDE_Y_HI = 7'd119
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     frameTick,
  output logic                     slideStart,
  output logic [X_W-1:0]           slideLowerX,
  output logic [X_W-1:0]           slideUpperX,
  output logic [Y_W-1:0]           slideLowerY,
  output logic [Y_W-1:0]           slideUpperY,
  input  logic                     slideDone,
  input  logic [X_W-1:0]           slideX,
  input  logic [Y_W-1:0]           slideY,
  input  logic [COL_W-1:0]         slideColour,
  input  logic                     slideWriteEn,
  input  logic [NUM_REQ-1:0]       reqValid,
  input  logic [X_W*NUM_REQ-1:0]   reqX,
  input  logic [Y_W*NUM_REQ-1:0]   reqY,
  input  logic [COL_W*NUM_REQ-1:0] reqColour,
  input  logic [NUM_REQ-1:0]       reqWriteEn,
  output logic [NUM_REQ-1:0]       grant,
  output logic [X_W-1:0]           vgaX,
  output logic [Y_W-1:0]           vgaY,
  output logic [COL_W-1:0]         vgaColour,
  output logic                     vgaWriteEn,
  output logic                     busy
`ifdef FRAME_SCHED_OVERRUN_EN
  ,
  output logic [7:0]               overrunCount,
  output logic [0:0]               overrun
`endif
);

  localparam int PTR_W = ptrWidth(NUM_REQ);

  sched_state_e state_q, state_d;
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [X_W-1:0]     vgaX_q, vgaX_d;
  logic [Y_W-1:0]     vgaY_q, vgaY_d;
  logic [COL_W-1:0]   vgaColour_q, vgaColour_d;
  logic               vgaWriteEn_q, vgaWriteEn_d;

  logic [NUM_REQ-1:0] pick;
  logic               anyValid;
  logic [PTR_W-1:0]   nextPtr;

  logic               srcActive;
  logic [X_W-1:0]     srcX;
  logic [Y_W-1:0]     srcY;
  logic [COL_W-1:0]   srcColour;
  logic               srcWriteEn;

  assign slideLowerX = SLIDE_X_LO;
  assign slideUpperX = SLIDE_X_HI;
  assign slideLowerY = SLIDE_Y_LO;
  assign slideUpperY = SLIDE_Y_HI;

  assign slideStart = (state_q == SLIDE_START);
  assign busy       = (state_q != IDLE);
  assign grant      = grant_q;
  assign vgaX       = vgaX_q;
  assign vgaY       = vgaY_q;
  assign vgaColour  = vgaColour_q;
  assign vgaWriteEn = vgaWriteEn_q;

  rr_arbiter_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .reqValid (reqValid),
    .rrPtr    (rrPtr_q),
    .pick     (pick),
    .anyValid (anyValid)
  );

  // Select the current write source and the pointer just past the granted requester.
  always_comb begin
    srcActive  = 1'b0;
    srcX       = '0;
    srcY       = '0;
    srcColour  = '0;
    srcWriteEn = 1'b0;
    nextPtr    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        nextPtr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    if (state_q == SLIDE_RUN) begin
      srcActive  = 1'b1;
      srcX       = slideX;
      srcY       = slideY;
      srcColour  = slideColour;
      srcWriteEn = slideWriteEn;
    end else if (state_q == DRAW) begin
      srcActive = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i]) begin
          srcX       = reqX[i*X_W +: X_W];
          srcY       = reqY[i*Y_W +: Y_W];
          srcColour  = reqColour[i*COL_W +: COL_W];
          srcWriteEn = reqWriteEn[i];
        end
      end
    end
  end

  // Next-state logic: slider phase first, then grant requesters one at a time.
  always_comb begin
    state_d = state_q;
    rrPtr_d = rrPtr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE:        if (frameTick) state_d = SLIDE_START;
      SLIDE_START: state_d = SLIDE_ARM;
      SLIDE_ARM:   state_d = SLIDE_RUN;
      SLIDE_RUN:   if (slideDone) state_d = ARB;
      ARB: begin
        if (anyValid) begin
          grant_d = pick;
          state_d = DRAW;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        if ((reqValid & grant_q) == '0) begin
          grant_d = '0;
          rrPtr_d = nextPtr;
          state_d = ARB;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Write port register: load from the active source, otherwise hold coordinates and stop writing.
  always_comb begin
    vgaX_d       = vgaX_q;
    vgaY_d       = vgaY_q;
    vgaColour_d  = vgaColour_q;
    vgaWriteEn_d = 1'b0;
    if (srcActive) begin
      vgaX_d       = srcX;
      vgaY_d       = srcY;
      vgaColour_d  = srcColour;
      vgaWriteEn_d = srcWriteEn;
    end
  end

  // State, arbitration and write-port registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rrPtr_q      <= '0;
      grant_q      <= '0;
      vgaX_q       <= '0;
      vgaY_q       <= '0;
      vgaColour_q  <= '0;
      vgaWriteEn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rrPtr_q      <= rrPtr_d;
      grant_q      <= grant_d;
      vgaX_q       <= vgaX_d;
      vgaY_q       <= vgaY_d;
      vgaColour_q  <= vgaColour_d;
      vgaWriteEn_q <= vgaWriteEn_d;
    end
  end

`ifdef FRAME_SCHED_OVERRUN_EN
  logic [7:0] overrunCount_q;
  logic       overrun_q;

  assign overrunCount = overrunCount_q;
  assign overrun      = overrun_q;

  // Count frame ticks that arrive while a frame is still in progress (saturating).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overrunCount_q <= '0;
      overrun_q      <= 1'b0;
    end else if (frameTick && (state_q != IDLE)) begin
      if (overrunCount_q != 8'hFF) overrunCount_q <= overrunCount_q + 8'd1;
      overrun_q <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
- Per-frame sequencer and VGA write-port arbiter for the scrolling display.
- On each frame tick it starts the screen slider over a fixed region and waits for it to finish.
- It then grants the shared VGA write port round-robin to up to NUM_REQ draw engines (player, obstacles, new column).
- It sits between the draw engines and the VGA adapter and is the only driver of the adapter's x/y/colour/writeEn.

Parameters:
- NUM_REQ, 3, number of draw-engine requesters (1..8).
- SLIDE_X_LO, 8'd0, slider lower x bound.
- SLIDE_X_HI, 8'd158, slider upper x bound.
- SLIDE_Y_LO, 7'd0, slider lower y bound.
- SLIDE_Y_HI, 7'd119, slider upper y bound.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- frameTick  in  1  one-cycle pulse at frame start.
- slideStart  out  1  one-cycle start pulse to the slider.
- slideLowerX/slideUpperX  out  8  slider x bounds (constant from parameters).
- slideLowerY/slideUpperY  out  7  slider y bounds (constant from parameters).
- slideDone  in  1  slider done; high in idle, low while running.
- slideX  in  8; slideY  in  7; slideColour  in  3; slideWriteEn  in  1  slider write request.
- reqValid  in  NUM_REQ  requester i holds high until its drawing is complete.
- reqX  in  8*NUM_REQ; reqY  in  7*NUM_REQ; reqColour  in  3*NUM_REQ; reqWriteEn  in  NUM_REQ  flattened requester writes; slice i = requester i.
- grant  out  NUM_REQ  one-hot grant (all zero when no grant).
- vgaX  out  8; vgaY  out  7; vgaColour  out  3; vgaWriteEn  out  1  registered VGA write port.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, slideStart=0, grant=0, vgaX=0, vgaY=0, vgaColour=0, vgaWriteEn=0, busy=0, rrPtr=0. Reset mid-operation aborts immediately; the slider is not restarted.
- States:
  - IDLE: when frameTick=1, go to SLIDE_START.
  - SLIDE_START: slideStart=1 for exactly this cycle; next state is SLIDE_ARM.
  - SLIDE_ARM: one cycle. slideDone is ignored here because the slider still shows stale done=1. Next state is SLIDE_RUN.
  - SLIDE_RUN: wait for slideDone=1, then go to ARB.
  - ARB: if any reqValid is set, grant the first set bit searching from rrPtr upward with wrap, then go to DRAW. If none is set, go to IDLE.
  - DRAW: grant held while reqValid[g]=1. When reqValid[g] falls, drop the grant, set rrPtr=(g+1) mod NUM_REQ, and go to ARB.
- Write-port mux: the source is the slider in SLIDE_RUN, requester g in DRAW, and none otherwise.
  - The vga* outputs are the source's x/y/colour/writeEn registered one cycle (latency 1).
  - With no source, vgaWriteEn=0 and vgaX/vgaY/vgaColour hold their previous values.
  - reqWriteEn from a non-granted requester never reaches the port.
- A requester may assert reqValid at any time; a grant is only issued in ARB. The slider phase always precedes draw grants within a frame.
- frameTick while busy=1 is dropped. It never restarts or preempts the current sequence.
- A frameTick in the same cycle the scheduler returns to IDLE is dropped. It is sampled only while in IDLE.
- Fairness: no requester is granted twice in a frame while another continuously valid requester waits.
- Constant outputs: slideLowerX etc. equal their parameters at all times, including during reset.

Optional Feature:
- Macro: FRAME_SCHED_OVERRUN_EN.
- Defined: adds output overrunCount [7:0]. Reset 0. Increments by 1, saturating at 255, on each frameTick sampled while busy=1. Also adds output overrun [0:0], set on the first such event and cleared only by reset.
- Undefined: both ports and the counter are absent; dropped ticks are silent.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SLIDE_START, SLIDE_ARM, SLIDE_RUN, ARB, DRAW);
  - X_W=8, Y_W=7, COL_W=3;
  - screen limit constants 160x120.
- Natural sub-module: rr_arbiter_pick. Combinational; inputs reqValid and rrPtr; outputs one-hot pick and anyValid. It is reusable by other shared-resource blocks.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles → all outputs 0, busy=0. No frameTick → slideStart never asserts.
- Slider sequencing: frameTick at t0 → slideStart=1 at t0+1 only. Model slider drops done at t0+2 and raises it at t0+50 → state ARB at t0+51. vga* follows slider writes with 1-cycle latency throughout t0+3..t0+50.
- Round-robin: reqValid=3'b111 held, each drop after 10 cycles → grant order 001,010,100. Next frame starts from rrPtr=0 → order 001,010,100. If only requester 2 is valid after requester 0 → it is granted next.
- Isolation: requester 1 asserts reqWriteEn=1 with x=8'd77 while requester 0 is granted → vgaX never 77 and vgaWriteEn is driven only by requester 0.
- Dropped tick: frameTick during SLIDE_RUN → no second slideStart. With FRAME_SCHED_OVERRUN_EN, overrunCount=1 and overrun=1.
- Reset mid-DRAW: reset_n=0 while grant=010 → next cycle grant=0, vgaWriteEn=0, state IDLE.
